// File: rtl/cache_control_if.sv
// CPU, physical-memory and line-array signals of the L1 cache controller.
// Modport master is the controller; slave is the CPU / memory / array side.
interface cache_control_if;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic         mem_resp;
    logic [15:0]  mem_rdata;

    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    logic [2:0]   array_index;
    logic         array_write;
    logic [127:0] array_datain;
    logic [127:0] array_dataout;

    modport master (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  pmem_rdata, pmem_resp, array_dataout,
        output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
        output array_index, array_write, array_datain
    );

    modport slave (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output pmem_rdata, pmem_resp, array_dataout,
        input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  array_index, array_write, array_datain
    );
endinterface

// File: rtl/cache_control.sv
// Write-back, write-allocate controller for the direct-mapped LC3B L1 cache.
// Define CACHE_PERF_CNT_EN to add saturating hit_count / miss_count outputs.
module cache_control #(
    parameter int TAG_W = 9,
    parameter int LINES = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    cache_control_if.master bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count
`endif
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic             tag_we;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             req;
    logic             is_write;
    logic             hit;
    logic             unused_addr_lsb;

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [2:0]   sel,
                                                input logic [15:0]  wdata,
                                                input logic [1:0]   be);
        logic [127:0] res;
        logic [15:0]  word;
        res  = line;
        word = line[{sel, 4'b0} +: 16];
        if (be[0]) word[7:0]  = wdata[7:0];
        if (be[1]) word[15:8] = wdata[15:8];
        res[{sel, 4'b0} +: 16] = word;
        return res;
    endfunction

    assign idx             = bus.mem_address[4 +: IDX_W];
    assign req_tag         = bus.mem_address[15 -: TAG_W];
    assign word_sel        = bus.mem_address[3:1];
    assign req             = bus.mem_read | bus.mem_write;
    // A simultaneous read and write is serviced as a write.
    assign is_write        = bus.mem_write;
    assign hit             = valid_q[idx] & (tag_q[idx] == req_tag);
    assign bus.array_index = bus.mem_address[6:4];
    assign unused_addr_lsb = bus.mem_address[0];

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_we           = 1'b0;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.array_write  = 1'b0;
        bus.array_datain = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                        if (is_write) begin
                            bus.array_write  = 1'b1;
                            bus.array_datain = merge_word(bus.array_dataout, word_sel,
                                                          bus.mem_wdata, bus.mem_byte_enable);
                            dirty_d[idx]     = 1'b1;
                        end else begin
                            bus.mem_rdata = bus.array_dataout[{word_sel, 4'b0} +: 16];
                        end
                    end else if (valid_q[idx] & dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[idx], idx, 4'b0};
                bus.pmem_wdata   = bus.array_dataout;
                if (bus.pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {bus.mem_address[15:4], 4'b0};
                if (bus.pmem_resp) begin
                    bus.array_write  = 1'b1;
                    bus.array_datain = bus.pmem_rdata;
                    tag_we           = 1'b1;
                    valid_d[idx]     = 1'b1;
                    dirty_d[idx]     = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags are masked by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[idx] <= req_tag;
    end

`ifdef CACHE_PERF_CNT_EN
    logic        miss_pend_q, miss_pend_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        start_miss;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_miss = (state_q == IDLE) && (state_d != IDLE);

    // miss_pend marks the first IDLE cycle after a miss so its response is not a hit.
    always_comb begin
        miss_pend_d = miss_pend_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (state_q == IDLE) begin
            miss_pend_d = start_miss;
            if (start_miss) miss_cnt_d = sat_inc(miss_cnt_q);
            if (bus.mem_resp && !miss_pend_q) hit_cnt_d = sat_inc(hit_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_pend_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            miss_pend_q <= miss_pend_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: doc/cache_control.md
# cache_control

Write-back, write-allocate controller for the LC3B direct-mapped L1 cache. Sits between the CPU memory port and physical memory, and drives the 8-entry × 128-bit cache line data array (combinational read, write on clock edge). Holds tag, valid and dirty state internally. Sequences hits, dirty-line writebacks and line fills.

## Interface
Parameters:
- `TAG_W`, default 9: tag width. Address split is tag[15:7], index[6:4], offset[3:0].
- `LINES`, default 8: number of cache lines. Must match the data array depth.

Ports (clock and reset first):
- `clk` in 1: clock. All state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: CPU read request. Held until `mem_resp`.
- `mem_write` in 1: CPU write request. Held until `mem_resp`.
- `mem_address` in 16: CPU byte address.
- `mem_wdata` in 16: CPU write word.
- `mem_byte_enable` in 2: [0] low byte, [1] high byte.
- `mem_resp` out 1: request complete.
- `mem_rdata` out 16: read word. Valid while `mem_resp` is 1.
- `pmem_read` out 1: line read request to physical memory.
- `pmem_write` out 1: line write request to physical memory.
- `pmem_address` out 16: line-aligned address, bits [3:0] = 0.
- `pmem_wdata` out 128: line being written back.
- `pmem_rdata` in 128: fill line.
- `pmem_resp` in 1: physical memory done, one-cycle pulse.
- `array_index` out 3: data array index, always `mem_address[6:4]`.
- `array_write` out 1: data array write strobe.
- `array_datain` out 128: line written into the data array.
- `array_dataout` in 128: current line from the data array.

## Operation
- States: IDLE, WRITEBACK, FILL. State reset value is IDLE.
- `req` = `mem_read` | `mem_write`. If both are asserted, the request is treated as a write.
- `hit` = `valid[idx]` & (`tag[idx]` == `mem_address[15:7]`).
- **IDLE, req & hit, read:**
  - `mem_resp` = 1.
  - `mem_rdata` = word `mem_address[3:1]` of `array_dataout`.
- **IDLE, req & hit, write:**
  - `array_write` = 1.
  - `array_datain` = `array_dataout` with the addressed word's enabled bytes replaced from `mem_wdata`.
  - `dirty[idx]` ← 1; `mem_resp` = 1.
- **IDLE, req & miss:**
  - If `valid[idx]` & `dirty[idx]`, go to WRITEBACK.
  - Otherwise go to FILL.
- **WRITEBACK:**
  - `pmem_write` = 1.
  - `pmem_address` = {`tag[idx]`, idx, 4'b0}.
  - `pmem_wdata` = `array_dataout`.
  - On `pmem_resp`: `dirty[idx]` ← 0, go to FILL.
- **FILL:**
  - `pmem_read` = 1.
  - `pmem_address` = {`mem_address[15:4]`, 4'b0}.
  - On `pmem_resp`: `array_write` = 1, `array_datain` = `pmem_rdata`, `tag[idx]` ← `mem_address[15:7]`, `valid[idx]` ← 1, `dirty[idx]` ← 0, go to IDLE.
  - The request then hits in IDLE.
- **Request dropped mid-miss:** the current WRITEBACK/FILL still completes, then the block returns to IDLE. No `mem_resp` is given.
- **`pmem_resp` in IDLE:** ignored.
- **Defaults:** all outputs not named above are 0. `pmem_wdata` = 0 outside WRITEBACK.

## Timing
- Reset values:
  - `valid[*]` = 0 and `dirty[*]` = 0; tags are don't-care.
  - `mem_resp`, `pmem_read`, `pmem_write`, `array_write` = 0.
  - `pmem_address`, `mem_rdata`, `pmem_wdata`, `array_datain` = 0.
- Reset asserted mid-miss: outputs drop to 0 immediately (asynchronously) and the FSM returns to IDLE. The data array contents are not cleared; valid = 0 masks them.
- Hit latency: `mem_resp` is combinational, in the same cycle the request is presented in IDLE.
- Clean miss: FILL is entered at edge 1. `mem_resp` comes 1 cycle after the `pmem_resp` cycle.
- Dirty miss: WRITEBACK, then FILL, then IDLE. `mem_resp` comes 1 cycle after the fill's `pmem_resp`.
- `pmem_read`/`pmem_write` are held steady until `pmem_resp`. They deassert in the cycle after the `pmem_resp` cycle.
- Tag, valid and dirty update on the same edge as the array write.

## Configuration
- Macro `CACHE_PERF_CNT_EN`.
- **Defined:** adds output ports `hit_count` [15:0] and `miss_count` [15:0].
  - Each is a saturating counter, reset to 0.
  - `hit_count` increments on each IDLE-cycle `mem_resp` whose request did not miss first.
  - `miss_count` increments on each IDLE→WRITEBACK/FILL transition.
  - Both saturate at 16'hFFFF.
- **Undefined:** the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- **Cold read miss:** after reset, read 0x0122 with `pmem_rdata` = 128'h0007_0006_..._0000, 3-cycle pmem latency.
  - `pmem_read` with address 0x0120, no `pmem_write`.
  - Then `mem_rdata` = 0x0001 with `mem_resp`.
- **Write hit merge:** line 0x0120 resident; write 0x0124 with data 0xABCD, byte_enable 2'b10.
  - Word 2 becomes 0xAB02 in the same cycle as `mem_resp`.
  - `dirty[2]` = 1.
- **Dirty eviction:** after the write-hit test, read 0x8120.
  - `pmem_write` with address 0x0120 and word 2 = 0xAB02, then `pmem_read` with address 0x8120.
  - Then `mem_resp`; a later read of 0x0120 misses.
- **Clean eviction:** read 0x0130, then 0x4130.
  - No `pmem_write`; only `pmem_read` with address 0x4130.
- **Async reset mid-FILL:** drop `reset_n` while `pmem_read` = 1.
  - `pmem_read` falls without waiting for a clock.
  - After release, a read of the previously filled address misses.
- **Dropped request and stray pmem_resp:**
  - Deassert `mem_read` during FILL: the fill completes and no `mem_resp` is given.
  - `pmem_resp` pulsed in IDLE: no state change.
  - With `CACHE_PERF_CNT_EN` defined, `miss_count` = 1 and `hit_count` = 0.
